tmds_encoder: RTL

- One TMDS channel encoder: DVI/HDMI 8b/10b transition-minimising, DC-balancing encoder.
- Sits between the colour-bar/timing generator (24-bit RGB, hsync, vsync, de on the pixel clock) and the 10:1 serialiser/differential output stage.
- Three instances per link: B carries {vsync,hsync} as c1/c0; G and R carry c1=c0=0.
- Emits a 10-bit symbol every pixel clock with a fixed 2-cycle pipeline latency.

---
 rtl/tmds_encoder.sv | 87 ++++++++
 1 files changed

// File: rtl/tmds_encoder.sv
// tmds_encoder: one DVI TMDS channel, 8b/10b transition-minimising DC-balancing encoder
// Ports:
//   clk     pixel clock, all registers on rising edge
//   rst     asynchronous active-low reset
//   din     8-bit pixel component, used when de=1
//   c0, c1  control bits, used when de=0
//   de      data enable (1 = active video, 0 = control period)
//   dout    10-bit TMDS symbol, dout[0] sent first, 2-cycle latency
//   dout_de de delayed to line up with dout
module tmds_encoder #(
    parameter int CNT_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       c0,
    input  logic       c1,
    input  logic       de,
    output logic [9:0] dout,
    output logic       dout_de
);
    logic [7:0] din_q;
    logic       de_q;
    logic [1:0] c_q;
    logic [3:0] n1d_q, n1d_d;
    logic [9:0] dout_q, dout_d, data_sym, ctrl_sym;
    logic       dout_de_q;
    logic signed [CNT_W-1:0] cnt_q, cnt_d, cnt_data, diff;
    logic [8:0] q_m;
    logic [3:0] n1q;
    logic       xnor_sel, sel_a, sel_b;

    always_comb begin
        n1d_d = '0;
        for (int i = 0; i < 8; i++) n1d_d = n1d_d + 4'(din[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_q     <= '0;
            de_q      <= 1'b0;
            c_q       <= '0;
            n1d_q     <= '0;
            dout_q    <= 10'h354;
            dout_de_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            din_q     <= din;
            de_q      <= de;
            c_q       <= {c1, c0};
            n1d_q     <= n1d_d;
            dout_q    <= dout_d;
            dout_de_q <= de_q;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        xnor_sel = n1d_q > 4'd4 || (n1d_q == 4'd4 && !din_q[0]);
        q_m      = '0;
        q_m[0]   = din_q[0];
        for (int i = 1; i < 8; i++) q_m[i] = xnor_sel ? ~(q_m[i-1] ^ din_q[i]) : q_m[i-1] ^ din_q[i];
        q_m[8]   = ~xnor_sel;
        n1q      = '0;
        for (int i = 0; i < 8; i++) n1q = n1q + 4'(q_m[i]);
        // n1q - n0q = 2*n1q - 8, always within -8..+8
        diff     = (CNT_W'(n1q) <<< 1) - CNT_W'(8);
        sel_a    = cnt_q == '0 || diff == '0;
        // outside branch A both are non-zero, so matching signs mean "same direction"
        sel_b    = cnt_q[CNT_W-1] == diff[CNT_W-1];
        data_sym = sel_a ? {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]} :
                   sel_b ? {1'b1, q_m[8], ~q_m[7:0]} :
                           {1'b0, q_m[8], q_m[7:0]};
        cnt_data = sel_a ? cnt_q + (q_m[8] ? diff : -diff) :
                   sel_b ? cnt_q + (q_m[8] ? CNT_W'(2) : CNT_W'(0)) - diff :
                           cnt_q + diff - (q_m[8] ? CNT_W'(0) : CNT_W'(2));
        ctrl_sym = c_q == 2'b00 ? 10'h354 :
                   c_q == 2'b01 ? 10'h0AB :
                   c_q == 2'b10 ? 10'h154 : 10'h2AB;
        dout_d   = de_q ? data_sym : ctrl_sym;
        // disparity restarts from zero at every control period
        cnt_d    = de_q ? cnt_data : '0;
    end

    assign dout    = dout_q;
    assign dout_de = dout_de_q;
endmodule
